// File: rtl/conv1x1_engine_pkg.sv
// Shared definitions for the pointwise convolution engine: FSM encodings,
// accumulator sizing and the output rescale/saturate stage.
// Pure declarations: no clocked logic, no ports.
package conv1x1_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    // Accumulator width: full product plus growth over CHIN terms, so a
    // whole pixel can be summed without overflow.
    function automatic int acc_width(input int width, input int chin);
        return 2 * width + $clog2(chin);
    endfunction

    // Arithmetic shift down by frac, then clamp into the signed width-bit
    // range. With relu set, negatives clamp to zero instead of to min.
    function automatic longint rescale(input longint s, input int frac,
                                       input int width, input bit relu);
        longint r;
        longint max_pos;
        longint min_neg;
        max_pos = (longint'(1) <<< (width - 1)) - 1;
        min_neg = -(longint'(1) <<< (width - 1));
        r = s >>> frac;
        if (relu && r < 0)
            r = 0;
        else if (r > max_pos)
            r = max_pos;
        else if (!relu && r < min_neg)
            r = min_neg;
        return r;
    endfunction

endpackage

// File: rtl/conv1x1_engine_if.sv
// Streaming interface of the engine: channel-serial input beats in,
// whole output pixels (all CHOUT channels packed, lane 0 in the LSBs) out.
// slave = engine side, master = producer/consumer side.
interface conv1x1_engine_if #(
    parameter int WIDTH = 16,
    parameter int CHOUT = 64
);
    logic                     ifm_valid;
    logic                     ifm_ready;
    logic [WIDTH-1:0]         ifm_data;
    logic                     ofm_valid;
    logic                     ofm_ready;
    logic [CHOUT*WIDTH-1:0]   ofm_data;

    modport slave (
        input  ifm_valid, ifm_data, ofm_ready,
        output ifm_ready, ofm_valid, ofm_data
    );

    modport master (
        output ifm_valid, ifm_data, ofm_ready,
        input  ifm_ready, ofm_valid, ofm_data
    );
endinterface

// File: rtl/conv1x1_engine_lane.sv
// One output channel: signed MAC over CHIN beats, then bias/rescale/ReLU into
// the lane's slot of the output buffer. Result registered on the final beat.
// No backpressure of its own; beat/last are already qualified by the top.
module conv1x1_lane
    import conv1x1_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14,
    parameter int CHIN  = 16,
    parameter int RELU  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      beat,
    input  logic                      last,
    input  logic signed [WIDTH-1:0]   x,
    input  logic signed [WIDTH-1:0]   w,
    input  logic signed [2*WIDTH-1:0] bias,
    output logic [WIDTH-1:0]          q
);
    localparam int AW = acc_width(WIDTH, CHIN);

    logic signed [AW-1:0]    acc;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW:0]      sum;
    logic signed [63:0]      res;

    assign prod = x * w;
    // The final beat's product and the bias fold straight into the result,
    // so there is no extra cycle between the last beat and the output load.
    assign sum  = (AW+1)'(acc) + (AW+1)'(prod) + (AW+1)'(bias);
    assign res  = rescale(64'(sum), FRAC, WIDTH, RELU != 0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            q   <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (beat) begin
            if (last) begin
                acc <= '0;
                q   <= res[WIDTH-1:0];
            end else begin
                acc <= acc + AW'(prod);
            end
        end
    end
endmodule

// File: rtl/conv1x1_engine.sv
// Time-shared 1x1 convolution: CHOUT MAC lanes over channel-serial input,
// result one cycle after a pixel's final beat, one pixel per CHIN cycles.
// Only the final beat of a pixel stalls, and only while the previous result is undrained.
module conv1x1_engine
    import conv1x1_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 14,
    parameter int CHIN       = 16,
    parameter int CHOUT      = 64,
    parameter int WOUT       = 64,
    parameter int NUM_LAYERS = 2,
    parameter int RELU       = 1,
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int CW = $clog2(CHIN),
    localparam int PW = $clog2(WOUT*WOUT) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LW-1:0]              layer_sel,
    output logic [LW-1:0]              w_layer,
    output logic [CW-1:0]              w_addr,
    input  logic [CHOUT*WIDTH-1:0]     w_data,
    input  logic [CHOUT*2*WIDTH-1:0]   bias,
    conv1x1_engine_if.slave            stream,
    output logic                       busy,
    output logic                       done,
    output logic [PW-1:0]              pix_count
);
    localparam int NPIX = WOUT * WOUT;

    state_t                  state;
    logic [PW-1:0]           pix_in;
    logic                    out_valid;
    logic [CHOUT*WIDTH-1:0]  out_data;
    logic                    last_beat;
    logic                    beat;
    logic                    load;
    logic                    drain;
    logic                    start_ok;

    assign last_beat = (w_addr == CW'(CHIN - 1));
    assign beat      = stream.ifm_valid && stream.ifm_ready;
    assign load      = beat && last_beat;
    assign drain     = out_valid && stream.ofm_ready;
    assign start_ok  = start && (state == S_IDLE);

    // Beats 0..CHIN-2 only touch accumulators, so they never wait; the
    // final beat overwrites the buffer and must wait for it (or drain with it).
    assign stream.ifm_ready = (state == S_RUN) &&
                              !(last_beat && out_valid && !stream.ofm_ready);
    assign stream.ofm_valid = out_valid;
    assign stream.ofm_data  = out_data;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            w_layer   <= '0;
            w_addr    <= '0;
            pix_in    <= '0;
            pix_count <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  if (start_ok) state <= S_RUN;
                S_RUN:   if (load && pix_in == PW'(NPIX - 1)) state <= S_DRAIN;
                S_DRAIN: if (drain && pix_count == PW'(NPIX - 1)) state <= S_DONE;
                default: state <= S_IDLE;
            endcase

            if (start_ok) begin
                w_layer   <= layer_sel;
                w_addr    <= '0;
                pix_in    <= '0;
                pix_count <= '0;
            end else begin
                if (beat)
                    w_addr <= last_beat ? '0 : w_addr + 1'b1;
                if (load)
                    pix_in <= pix_in + 1'b1;
                if (drain)
                    pix_count <= pix_count + 1'b1;
            end

            // Load wins over drain: a same-edge drain+load keeps valid high.
            if (load)
                out_valid <= 1'b1;
            else if (drain)
                out_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < CHOUT; i++) begin : g_lane
        conv1x1_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .CHIN  (CHIN),
            .RELU  (RELU)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (start_ok),
            .beat (beat),
            .last (last_beat),
            .x    (stream.ifm_data),
            .w    (w_data[i*WIDTH +: WIDTH]),
            .bias (bias[i*2*WIDTH +: 2*WIDTH]),
            .q    (out_data[i*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_conv1x1_engine.sv
module tb_conv1x1_engine;
    localparam int WIDTH = 16;
    localparam int FRAC  = 14;
    localparam int CHIN  = 16;
    localparam int CHOUT = 4;
    localparam int WOUT  = 2;
    localparam int NL    = 2;
    localparam int NPIX  = WOUT * WOUT;

    logic clk;
    logic rst;
    logic start;
    logic [0:0] layer_sel;
    logic ifm_valid;
    logic [15:0] ifm_data;
    logic ofm_ready;

    logic [0:0]   w_layer_r, w_layer_s;
    logic [3:0]   w_addr_r, w_addr_s;
    logic [63:0]  w_data_r, w_data_s;
    logic [127:0] bias_r, bias_s;
    logic         busy_r, busy_s, done_r, done_s;
    logic [2:0]   pix_count_r, pix_count_s;

    logic [15:0] wrom [0:1][0:15][0:3];
    logic [31:0] brom [0:1][0:3];
    logic [15:0] px [0:15];

    logic [63:0] q_r[$];
    logic [63:0] q_s[$];
    int hs_t[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_hs = 0;
    int cur_layer = 0;

    conv1x1_engine_if #(.WIDTH(WIDTH), .CHOUT(CHOUT)) if_r ();
    conv1x1_engine_if #(.WIDTH(WIDTH), .CHOUT(CHOUT)) if_s ();

    assign if_r.ifm_valid = ifm_valid;
    assign if_r.ifm_data  = ifm_data;
    assign if_r.ofm_ready = ofm_ready;
    assign if_s.ifm_valid = ifm_valid;
    assign if_s.ifm_data  = ifm_data;
    assign if_s.ofm_ready = ofm_ready;

    conv1x1_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .CHIN(CHIN), .CHOUT(CHOUT),
                     .WOUT(WOUT), .NUM_LAYERS(NL), .RELU(1)) u_dut_r (
        .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
        .w_layer(w_layer_r), .w_addr(w_addr_r), .w_data(w_data_r), .bias(bias_r),
        .stream(if_r), .busy(busy_r), .done(done_r), .pix_count(pix_count_r));

    conv1x1_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .CHIN(CHIN), .CHOUT(CHOUT),
                     .WOUT(WOUT), .NUM_LAYERS(NL), .RELU(0)) u_dut_s (
        .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
        .w_layer(w_layer_s), .w_addr(w_addr_s), .w_data(w_data_s), .bias(bias_s),
        .stream(if_s), .busy(busy_s), .done(done_s), .pix_count(pix_count_s));

    // Weight ROM / bias table, combinational on each DUT's own address.
    always_comb begin
        w_data_r = '0;
        w_data_s = '0;
        bias_r   = '0;
        bias_s   = '0;
        for (int l = 0; l < CHOUT; l++) begin
            w_data_r[l*16 +: 16] = wrom[w_layer_r][w_addr_r][l];
            w_data_s[l*16 +: 16] = wrom[w_layer_s][w_addr_s][l];
            bias_r[l*32 +: 32]   = brom[w_layer_r][l];
            bias_s[l*32 +: 32]   = brom[w_layer_s][l];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer dot product, Q2.14 rescale, clamp to int16.
    function automatic logic [63:0] model(input int layer, input bit relu);
        logic [63:0] o;
        longint s;
        longint r;
        o = '0;
        for (int l = 0; l < CHOUT; l++) begin
            s = longint'($signed(brom[layer][l]));
            for (int c = 0; c < CHIN; c++)
                s += longint'($signed(px[c])) * longint'($signed(wrom[layer][c][l]));
            r = s >>> 14;
            if (relu && r < 0) r = 0;
            else if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
            o[l*16 +: 16] = r[15:0];
        end
        return o;
    endfunction

    function automatic logic [15:0] rnd16(input int span);
        int v;
        v = int'($urandom_range(0, 2 * span)) - span;
        return v[15:0];
    endfunction

    // Output side: compare every handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst && if_r.ofm_valid && ofm_ready) begin
            if (q_r.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL ofm_unexpected got=%h exp=none", if_r.ofm_data);
            end else begin
                chk("ofm_relu", if_r.ofm_data, q_r.pop_front());
                chk("ofm_sat", if_s.ofm_data, q_s.pop_front());
                chk("w_layer", w_layer_r, cur_layer);
                hs_t.push_back(cyc);
                last_hs = cyc;
            end
        end
    end

    // Call only just after a rising edge.
    task automatic send_beat(input logic [15:0] d);
        bit ok;
        ok = 0;
        ifm_valid = 1'b1;
        ifm_data  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (if_r.ifm_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $error("FAIL beat_timeout got=no_ready exp=ready");
        end
        @(posedge clk); #1;
        ifm_valid = 1'b0;
    endtask

    task automatic send_pixel();
        q_r.push_back(model(cur_layer, 1'b1));
        q_s.push_back(model(cur_layer, 1'b0));
        for (int c = 0; c < CHIN; c++) send_beat(px[c]);
    endtask

    task automatic fill_px(input logic [15:0] v);
        for (int c = 0; c < CHIN; c++) px[c] = v;
    endtask

    task automatic rand_px();
        for (int c = 0; c < CHIN; c++) px[c] = rnd16(12000);
    endtask

    // Call just after a rising edge; leaves the bench just after a rising edge.
    task automatic do_start(input int layer);
        cur_layer = layer;
        layer_sel = layer[0:0];
        hs_t.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy_r, 1);
        chk("start_ifm_ready", if_r.ifm_ready, 1);
        @(posedge clk); #1;
    endtask

    // Leaves the bench just after the rising edge that starts the cycle after DONE.
    task automatic wait_done(input string tag);
        bit seen;
        seen = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done_r) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $error("FAIL %s_done_timeout got=0 exp=1", tag);
        end else begin
            chk({tag, "_done_cycle"}, cyc, last_hs + 1);
            chk({tag, "_done_s"}, done_s, 1);
            chk({tag, "_pix_count"}, pix_count_r, NPIX);
            @(posedge clk); #1;
            chk({tag, "_done_pulse"}, done_r, 0);
            chk({tag, "_idle"}, busy_r, 0);
        end
    endtask

    initial begin
        int t0;
        rst = 1'b0;
        start = 1'b0;
        layer_sel = '0;
        ifm_valid = 1'b0;
        ifm_data = '0;
        ofm_ready = 1'b1;
        for (int c = 0; c < CHIN; c++)
            for (int l = 0; l < CHOUT; l++) begin
                wrom[0][c][l] = 16'h4000;
                wrom[1][c][l] = 16'hC000;
            end
        for (int l = 0; l < CHOUT; l++) brom[0][l] = 32'd0;
        brom[1][0] = 32'd0;
        brom[1][1] = 32'd0;
        brom[1][2] = 32'h0010_0000;
        brom[1][3] = 32'hFFF0_0000;
        fill_px(16'h0);

        repeat (3) @(negedge clk);
        chk("rst_ifm_ready", if_r.ifm_ready, 0);
        chk("rst_ofm_valid", if_r.ofm_valid, 0);
        chk("rst_ofm_data", if_r.ofm_data, 0);
        chk("rst_busy", busy_r, 0);
        chk("rst_done", done_r, 0);
        chk("rst_pix_count", pix_count_r, 0);
        chk("rst_w_addr", w_addr_r, 0);
        chk("rst_w_layer", w_layer_r, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Layer 0, unit weights: 1.0 -> 16.0 saturates; 0.5 -> 8.0 saturates;
        // 1/64 -> 0.25 = 0x1000; then a mixed pixel.
        do_start(0);
        fill_px(16'h4000); send_pixel();
        fill_px(16'h2000); send_pixel();
        fill_px(16'h0100); send_pixel();
        rand_px();         send_pixel();
        wait_done("layer0");
        if (hs_t.size() >= 2) chk("throughput", hs_t[1] - hs_t[0], CHIN);
        else begin
            checks++;
            failures++;
            $error("FAIL throughput got=%0d exp=%0d handshakes", hs_t.size(), NPIX);
        end

        // Layer 1 (weights -1.0, per-lane bias), started the cycle after DONE.
        do_start(1);
        fill_px(16'h4000); send_pixel();
        ofm_ready = 1'b0;
        fill_px(16'h0100);
        q_r.push_back(model(1, 1'b1));
        q_s.push_back(model(1, 1'b0));
        t0 = cyc;
        for (int c = 0; c < CHIN - 1; c++) send_beat(px[c]);
        chk("no_stall_beats", cyc - t0, CHIN - 1);
        ifm_valid = 1'b1;
        ifm_data = px[CHIN-1];
        @(negedge clk);
        chk("stall_ifm_ready", if_r.ifm_ready, 0);
        chk("stall_w_addr", w_addr_r, CHIN - 1);
        repeat (40) @(negedge clk);
        chk("stall_ifm_ready_end", if_r.ifm_ready, 0);
        chk("stall_hold_relu", if_r.ofm_data, q_r[0]);
        chk("stall_hold_sat", if_s.ofm_data, q_s[0]);
        @(posedge clk); #1;
        ofm_ready = 1'b1;
        @(negedge clk);
        chk("release_ifm_ready", if_r.ifm_ready, 1);
        @(posedge clk); #1;
        ifm_valid = 1'b0;
        @(negedge clk);
        chk("overlap_ofm_valid", if_r.ofm_valid, 1);
        chk("overlap_w_addr", w_addr_r, 0);
        @(posedge clk); #1;
        rand_px(); send_pixel();
        rand_px(); send_pixel();
        wait_done("layer1");

        // Random layer-0 weights/bias, then reset in the middle of a pixel.
        for (int c = 0; c < CHIN; c++)
            for (int l = 0; l < CHOUT; l++) wrom[0][c][l] = rnd16(8192);
        for (int l = 0; l < CHOUT; l++) begin
            int b;
            b = int'($urandom_range(0, 1 << 27)) - (1 << 26);
            brom[0][l] = b;
        end
        do_start(0);
        rand_px();
        for (int c = 0; c < 7; c++) send_beat(px[c]);
        chk("mid_w_addr", w_addr_r, 7);
        rst = 1'b0;
        #1;
        chk("mid_rst_ifm_ready", if_r.ifm_ready, 0);
        chk("mid_rst_ofm_valid", if_r.ofm_valid, 0);
        chk("mid_rst_ofm_data_s", if_s.ofm_data, 0);
        chk("mid_rst_busy", busy_r, 0);
        chk("mid_rst_pix_count", pix_count_r, 0);
        chk("mid_rst_w_addr", w_addr_r, 0);
        chk("mid_rst_w_layer", w_layer_r, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        do_start(0);
        for (int p = 0; p < NPIX; p++) begin
            rand_px();
            send_pixel();
        end
        wait_done("recover");
        chk("queue_empty_r", q_r.size(), 0);
        chk("queue_empty_s", q_s.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
